// File: rtl/bcd_display_driver.sv
// Three-digit BCD to 7-segment display driver.
// Latches a packed BCD value over valid/ready and encodes one digit per cycle,
// most significant digit first, with optional leading-zero blanking. All three
// displays update together on COMMIT. It also provides a free-running blink
// and a sticky flag for non-decimal digits.
module bcd_display_driver #(
    parameter int unsigned BLINK_DIV  = 13500000,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] bcd_in,
    input  logic        bcd_valid,
    output logic        bcd_ready,
    input  logic        blank_lz,
    input  logic        blink_en,
    output logic        err_flag,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2
);

    localparam int unsigned CW       = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);
    localparam logic [6:0] SEG_POL   = ACTIVE_LOW ? 7'h00 : 7'h7F;
    localparam logic [6:0] SEG_OFF   = 7'h7F ^ SEG_POL;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SCAN2  = 3'd1,
        SCAN1  = 3'd2,
        SCAN0  = 3'd3,
        COMMIT = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [11:0]   hold_q, hold_d;
    logic          blz_q, blz_d;
    logic          lz_run_q, lz_run_d;
    logic          err_pend_q, err_pend_d;
    logic          err_q, err_d;
    logic [6:0]    stage2_q, stage2_d;
    logic [6:0]    stage1_q, stage1_d;
    logic [6:0]    stage0_q, stage0_d;
    logic [6:0]    disp2_q, disp2_d;
    logic [6:0]    disp1_q, disp1_d;
    logic [6:0]    disp0_q, disp0_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;

    logic [3:0]    digit;
    logic          digit_bad;
    logic          digit_blank;
    logic [6:0]    digit_pat;

    // Active-low pattern, bits [6:0] = g..a; non-decimal digits show a dash.
    function automatic logic [6:0] seg_lo(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = 7'b0111111;
        endcase
        return p;
    endfunction

    // Digit currently being scanned and its (possibly blanked) segment pattern.
    always_comb begin
        case (state_q)
            SCAN2:   digit = hold_q[11:8];
            SCAN1:   digit = hold_q[7:4];
            default: digit = hold_q[3:0];
        endcase
        digit_bad   = (digit > 4'd9);
        digit_blank = blz_q & lz_run_q & (digit == 4'd0) & (state_q != SCAN0);
        digit_pat   = digit_blank ? SEG_OFF : (seg_lo(digit) ^ SEG_POL);
    end

    // Next-state logic for the scan FSM, staging/display registers and blink timer.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        blz_d      = blz_q;
        lz_run_d   = lz_run_q;
        err_pend_d = err_pend_q;
        err_d      = err_q;
        stage2_d   = stage2_q;
        stage1_d   = stage1_q;
        stage0_d   = stage0_q;
        disp2_d    = disp2_q;
        disp1_d    = disp1_q;
        disp0_d    = disp0_q;

        case (state_q)
            IDLE: begin
                if (bcd_valid) begin
                    hold_d     = bcd_in;
                    blz_d      = blank_lz;
                    lz_run_d   = 1'b1;
                    err_pend_d = 1'b0;
                    state_d    = SCAN2;
                end
            end
            SCAN2: begin
                stage2_d   = digit_pat;
                lz_run_d   = lz_run_q & digit_blank;
                err_pend_d = err_pend_q | digit_bad;
                state_d    = SCAN1;
            end
            SCAN1: begin
                stage1_d   = digit_pat;
                lz_run_d   = lz_run_q & digit_blank;
                err_pend_d = err_pend_q | digit_bad;
                state_d    = SCAN0;
            end
            SCAN0: begin
                stage0_d   = digit_pat;
                lz_run_d   = lz_run_q & digit_blank;
                err_pend_d = err_pend_q | digit_bad;
                state_d    = COMMIT;
            end
            COMMIT: begin
                disp2_d = stage2_q;
                disp1_d = stage1_q;
                disp0_d = stage0_q;
                err_d   = err_q | err_pend_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + 1'b1;
            phase_d = phase_q;
        end
    end

    // State register; synchronous reset discards any in-flight transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            blz_q      <= 1'b0;
            lz_run_q   <= 1'b0;
            err_pend_q <= 1'b0;
            err_q      <= 1'b0;
            stage2_q   <= SEG_OFF;
            stage1_q   <= SEG_OFF;
            stage0_q   <= SEG_OFF;
            disp2_q    <= SEG_OFF;
            disp1_q    <= SEG_OFF;
            disp0_q    <= SEG_OFF;
            cnt_q      <= '0;
            phase_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            blz_q      <= blz_d;
            lz_run_q   <= lz_run_d;
            err_pend_q <= err_pend_d;
            err_q      <= err_d;
            stage2_q   <= stage2_d;
            stage1_q   <= stage1_d;
            stage0_q   <= stage0_d;
            disp2_q    <= disp2_d;
            disp1_q    <= disp1_d;
            disp0_q    <= disp0_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
        end
    end

    // Outputs: ready only in IDLE out of reset; blink overrides the display registers.
    always_comb begin
        bcd_ready = (state_q == IDLE) & ~reset;
        err_flag  = err_q;
        hex2      = (blink_en & phase_q) ? SEG_OFF : disp2_q;
        hex1      = (blink_en & phase_q) ? SEG_OFF : disp1_q;
        hex0      = (blink_en & phase_q) ? SEG_OFF : disp0_q;
    end

endmodule

// File: tb/tb_bcd_display_driver.sv
// Scoreboard bench for bcd_display_driver: stimulus pushes expected displays,
// a monitor pops and compares whenever a commit completes (bcd_ready re-rises).
module tb_bcd_display_driver;

    localparam logic [6:0] S_OFF  = 7'b1111111;
    localparam logic [6:0] S_DASH = 7'b0111111;
    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] bcd_in = '0;
    logic        bcd_valid = 1'b0;
    logic        bcd_ready;
    logic        blank_lz = 1'b0;
    logic        blink_en = 1'b0;
    logic        err_flag;
    logic [6:0]  hex0, hex1, hex2;

    int n_chk  = 0;
    int n_pass = 0;
    int acc_cnt = 0;
    logic mon_stable_en = 1'b1;

    // expected {hex2, hex1, hex0, err}
    logic [21:0] exp_q[$];

    // blink phase model
    int   m_cnt = 0;
    logic m_ph  = 1'b0;

    bcd_display_driver #(.BLINK_DIV(4), .ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .reset(reset), .bcd_in(bcd_in), .bcd_valid(bcd_valid),
        .bcd_ready(bcd_ready), .blank_lz(blank_lz), .blink_en(blink_en),
        .err_flag(err_flag), .hex0(hex0), .hex1(hex1), .hex2(hex2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(posedge clk) begin
        if (bcd_valid && bcd_ready) acc_cnt <= acc_cnt + 1;
        if (reset) begin
            m_cnt <= 0;
            m_ph  <= 1'b0;
        end else if (m_cnt == 3) begin
            m_cnt <= 0;
            m_ph  <= ~m_ph;
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        logic        p_rdy, p_rst;
        logic [20:0] p_hex;
        logic [21:0] e;
        int          low_run;
        p_rdy = 1'b0; p_rst = 1'b1; p_hex = '0; low_run = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!p_rdy && bcd_ready && !p_rst && !reset) begin
                chk("ready_low_cycles", low_run, 4);
                if (exp_q.size() == 0) begin
                    chk("unexpected_commit", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("hex2", hex2, e[21:15]);
                    chk("hex1", hex1, e[14:8]);
                    chk("hex0", hex0, e[7:1]);
                    chk("err_flag", err_flag, e[0]);
                end
            end else if (mon_stable_en && !reset && !p_rst && ({hex2, hex1, hex0} !== p_hex)) begin
                chk("display_changed_outside_commit", {hex2, hex1, hex0}, p_hex);
            end
            low_run = bcd_ready ? 0 : low_run + 1;
            p_rdy = bcd_ready;
            p_rst = reset;
            p_hex = {hex2, hex1, hex0};
        end
    end

    task automatic wait_ready();
        int t;
        t = 0;
        while (!bcd_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!bcd_ready) chk("ready_timeout", 0, 1);
    endtask

    // Returns at the falling edge after the accept edge.
    task automatic send(input logic [11:0] v, input logic blz,
                        input logic [6:0] e2, input logic [6:0] e1,
                        input logic [6:0] e0, input logic ee, input logic push);
        @(negedge clk);
        wait_ready();
        bcd_in = v;
        blank_lz = blz;
        bcd_valid = 1'b1;
        if (push) exp_q.push_back({e2, e1, e0, ee});
        @(negedge clk);
        bcd_valid = 1'b0;
        bcd_in = 12'hXXX;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("scoreboard_drained", exp_q.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        int a0;
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_hex", {hex2, hex1, hex0}, {S_OFF, S_OFF, S_OFF});
        chk("rst_err", err_flag, 0);
        chk("rst_ready", bcd_ready, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", bcd_ready, 1);

        send(12'h123, 1'b1, S1, S2, S3, 1'b0, 1'b1);
        send(12'h007, 1'b1, S_OFF, S_OFF, S7, 1'b0, 1'b1);
        send(12'h000, 1'b1, S_OFF, S_OFF, S0, 1'b0, 1'b1);
        send(12'h007, 1'b0, S0, S0, S7, 1'b0, 1'b1);
        send(12'h090, 1'b1, S_OFF, S9, S0, 1'b0, 1'b1);
        send(12'h102, 1'b1, S1, S0, S2, 1'b0, 1'b1);
        send(12'h0B0, 1'b1, S_OFF, S_DASH, S0, 1'b1, 1'b1);
        send(12'h1A5, 1'b1, S1, S_DASH, S5, 1'b1, 1'b1);
        send(12'h222, 1'b1, S2, S2, S2, 1'b1, 1'b1);
        drain();

        // valid held high for 10 edges: exactly 2 accepts (456 then 789)
        wait_ready();
        a0 = acc_cnt;
        exp_q.push_back({S4, S5, S6, 1'b1});
        exp_q.push_back({S7, S8, S9, 1'b1});
        bcd_in = 12'h456;
        blank_lz = 1'b0;
        bcd_valid = 1'b1;
        @(negedge clk);
        bcd_in = 12'h789;
        repeat (9) @(negedge clk);
        bcd_valid = 1'b0;
        chk("accepts_in_10_cycles", acc_cnt - a0, 2);
        drain();

        // blink with BLINK_DIV=4
        send(12'h321, 1'b0, S3, S2, S1, 1'b1, 1'b1);
        drain();
        mon_stable_en = 1'b0;
        blink_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("blink", {hex2, hex1, hex0},
                m_ph ? {S_OFF, S_OFF, S_OFF} : {S3, S2, S1});
        end
        while (!m_ph) @(negedge clk);
        blink_en = 1'b0;
        @(negedge clk);
        chk("blink_off_steady", {hex2, hex1, hex0}, {S3, S2, S1});
        repeat (3) @(negedge clk);
        chk("blink_off_steady2", {hex2, hex1, hex0}, {S3, S2, S1});
        mon_stable_en = 1'b1;

        // reset during SCAN1 aborts the transaction
        send(12'h999, 1'b0, S9, S9, S9, 1'b1, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_hex", {hex2, hex1, hex0}, {S_OFF, S_OFF, S_OFF});
        chk("abort_err", err_flag, 0);
        chk("abort_ready_in_reset", bcd_ready, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_ready_after", bcd_ready, 1);
        repeat (6) @(negedge clk);
        chk("abort_no_commit", {hex2, hex1, hex0, err_flag}, {S_OFF, S_OFF, S_OFF, 1'b0});
        chk("abort_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
